// File: rtl/hv_bundle_counter_bank.sv
// Bundling accumulator bank: per-core +1/-1 votes are summed and accumulated into
// one of DEPTH saturating signed counters; reads return the count and its bundled sign.
module hv_bundle_counter_bank #(
  parameter int NCORE = 16,
  parameter int W     = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_addr,
  input  logic [NCORE-1:0] in_mask,
  input  logic [NCORE-1:0] in_bit,
  input  logic             clear,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  input  logic             tie_bit,
  output logic             rd_valid,
  output logic [W-1:0]     rd_count,
  output logic             rd_sign,
  output logic             busy,
  output logic             ovf_sticky,
  output logic             dbg_state_o
);
  localparam int SW = $clog2(NCORE + 1) + 1;

  // Handshake: a store moves when in_valid && in_ready, a read when rd_req && !busy;
  // clear in the same cycle wins and neither is taken.
  typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     sweep_addr_q, sweep_addr_d;
  logic              sweep_we;

  logic              s0_valid_q, s1_valid_q;
  logic [AW-1:0]     s0_addr_q, s1_addr_q;
  logic [NCORE-1:0]  s0_mask_q, s0_bit_q;
  logic signed [SW-1:0] s1_sum_q, sum_d;

  logic              r0_valid_q, r1_valid_q;
  logic [AW-1:0]     r0_addr_q, r1_addr_q;
  logic              r0_tie_q, r1_tie_q;

  logic              rd_valid_q;
  logic [W-1:0]      rd_count_q, rd_cnt_d;
  logic              rd_sign_q, rd_sign_d;
  logic              ovf_q;

  logic [W-1:0]      cnt_q [DEPTH];
  logic [W-1:0]      cur_cnt, sat_val;
  logic [W:0]        wide_sum;
  logic              sat_hit;
  logic              accept_st, accept_rd;

  assign busy        = (state_q == ST_SWEEP);
  assign in_ready    = !busy;
  assign accept_st   = in_valid && in_ready && !clear;
  assign accept_rd   = rd_req && !busy && !clear;
  assign rd_valid    = rd_valid_q;
  assign rd_count    = rd_count_q;
  assign rd_sign     = rd_sign_q;
  assign ovf_sticky  = ovf_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    sweep_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d      = ST_SWEEP;
          sweep_addr_d = '0;
        end
      end
      ST_SWEEP: begin
        sweep_we = 1'b1;
        if (clear) begin
          sweep_addr_d = '0;
        end else if (sweep_addr_q == AW'(DEPTH - 1)) begin
          state_d      = ST_IDLE;
          sweep_addr_d = '0;
        end else begin
          sweep_addr_d = sweep_addr_q + AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NCORE; k++) begin
      if (s0_mask_q[k]) sum_d = s0_bit_q[k] ? sum_d + SW'(1) : sum_d - SW'(1);
    end
  end

  // The S2 read-modify-write completes in one cycle, so a same-address store one
  // cycle behind always sees the freshly written count: no update can be lost.
  always_comb begin
    cur_cnt  = cnt_q[s1_addr_q];
    wide_sum = {cur_cnt[W-1], cur_cnt} + {{(W + 1 - SW){s1_sum_q[SW-1]}}, s1_sum_q};
    sat_hit  = wide_sum[W] ^ wide_sum[W-1];
    sat_val  = wide_sum[W-1:0];
    if (sat_hit) sat_val = wide_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  // Sampled one cycle before the store accepted alongside the read lands.
  always_comb begin
    rd_cnt_d  = cnt_q[r1_addr_q];
    rd_sign_d = 1'b0;
    if (rd_cnt_d[W-1])         rd_sign_d = 1'b1;
    else if (rd_cnt_d == '0)   rd_sign_d = r1_tie_q;
  end

  always_ff @(posedge clk) begin
    if (sweep_we)        cnt_q[sweep_addr_q] <= '0;
    else if (s1_valid_q) cnt_q[s1_addr_q]    <= sat_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SWEEP;
      sweep_addr_q <= '0;
      s0_valid_q   <= 1'b0;
      s1_valid_q   <= 1'b0;
      s0_addr_q    <= '0;
      s1_addr_q    <= '0;
      s0_mask_q    <= '0;
      s0_bit_q     <= '0;
      s1_sum_q     <= '0;
      r0_valid_q   <= 1'b0;
      r1_valid_q   <= 1'b0;
      r0_addr_q    <= '0;
      r1_addr_q    <= '0;
      r0_tie_q     <= 1'b0;
      r1_tie_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_count_q   <= '0;
      rd_sign_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      s0_valid_q   <= accept_st;
      s0_addr_q    <= in_addr;
      s0_mask_q    <= in_mask;
      s0_bit_q     <= in_bit;
      s1_valid_q   <= s0_valid_q && !clear;
      s1_addr_q    <= s0_addr_q;
      s1_sum_q     <= sum_d;
      r0_valid_q   <= accept_rd;
      r0_addr_q    <= rd_addr;
      r0_tie_q     <= tie_bit;
      r1_valid_q   <= r0_valid_q && !clear;
      r1_addr_q    <= r0_addr_q;
      r1_tie_q     <= r0_tie_q;
      rd_valid_q   <= r1_valid_q && !clear;
      if (r1_valid_q && !clear) begin
        rd_count_q <= rd_cnt_d;
        rd_sign_q  <= rd_sign_d;
      end
      if (clear)                     ovf_q <= 1'b0;
      else if (s1_valid_q && sat_hit) ovf_q <= 1'b1;
    end
  end
endmodule
